demux_1_to_8_sipo: RTL and testbench

- Receive-side counterpart of the 8-to-1 data selector: a 1-to-8 time-division demultiplexer.
- Accepts a bit-serial stream and steers each bit to the output slot given by an internal 3-bit select counter.
- Presents a completed 8-bit word with a valid/ack handshake.
- Sits at the far end of a link where a selector sends D0..D7 in sequence on select codes 000..111.

---
 rtl/digital_logic_pkg.sv | 12 +
 rtl/dec_3_to_8.sv | 19 +
 rtl/demux_1_to_8_sipo.sv | 107 ++++++++++
 tb/tb_demux_1_to_8_sipo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/digital_logic_pkg.sv
// Shared definitions for the serial-link receive blocks: FSM state encoding
// and the default slot count.
package digital_logic_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage : digital_logic_pkg

// File: rtl/dec_3_to_8.sv
// One-hot select decoder with an active-high enable (138-style); width follows N.
module dec_3_to_8
  import digital_logic_pkg::*;
#(
  parameter int  N     = N_DEFAULT,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     y
);

  always_comb begin
    // NOTE: default every output first so no path through the block leaves y unassigned (no latch).
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule : dec_3_to_8

// File: rtl/demux_1_to_8_sipo.sv
// 1-to-N time-division demultiplexer: serial bits are steered into slots by a
// select counter and the completed word is offered with a VALID/ACK handshake.
module demux_1_to_8_sipo
  import digital_logic_pkg::*;
#(
  parameter int  N     = N_DEFAULT,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             G_n,
  input  logic             SYNC,
  input  logic             STB,
  input  logic             DIN,
  input  logic             ACK,
  output logic [SEL_W-1:0] S,
  output logic [N-1:0]     Q,
  output logic             VALID,
  output logic             OVERRUN,
  output logic             BUSY
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     q_q, q_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             last;
  logic [SEL_W-1:0] slot;
  logic [N-1:0]     we;

  assign accept = STB & ~G_n;
  // SYNC re-aligns the frame, so an accepted SYNC bit always lands in slot 0.
  assign slot   = SYNC ? '0 : s_q;
  assign last   = accept & ~SYNC & (state_q == COLLECT) & (s_q == SEL_W'(N - 1));

  dec_3_to_8 #(.N(N)) u_dec (
    .sel (slot),
    .en  (accept),
    .y   (we)
  );

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    shadow_d  = shadow_q;
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (SYNC) shadow_d = '0;
    for (int k = 0; k < N; k++) begin
      if (we[k]) shadow_d[k] = DIN;
    end

    if (accept) begin
      if (SYNC) begin
        s_d     = SEL_W'(1);
        state_d = COLLECT;
      end else begin
        s_d     = s_q + SEL_W'(1);
        state_d = last ? IDLE : COLLECT;
      end
    end else if (SYNC) begin
      s_d     = '0;
      state_d = IDLE;
    end

    // The last bit bypasses the shadow so Q is complete on the same edge.
    if (last) begin
      q_d     = {DIN, shadow_q[N-2:0]};
      valid_d = 1'b1;
      if (valid_q && !ACK) overrun_d = 1'b1;
    end else if (valid_q && ACK) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      shadow_q  <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q   <= state_d;
      s_q       <= s_d;
      shadow_q  <= shadow_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign S       = s_q;
  assign Q       = q_q;
  assign VALID   = valid_q;
  assign OVERRUN = overrun_q;
  assign BUSY    = (state_q == COLLECT);

endmodule : demux_1_to_8_sipo

// File: tb/tb_demux_1_to_8_sipo.sv
// Directed self-checking bench for demux_1_to_8_sipo (N=8).
module tb_demux_1_to_8_sipo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       G_n, SYNC, STB, DIN, ACK;
  logic [2:0] S;
  logic [7:0] Q;
  logic       VALID, OVERRUN, BUSY;

  int checks   = 0;
  int failures = 0;

  demux_1_to_8_sipo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .G_n     (G_n),
    .SYNC    (SYNC),
    .STB     (STB),
    .DIN     (DIN),
    .ACK     (ACK),
    .S       (S),
    .Q       (Q),
    .VALID   (VALID),
    .OVERRUN (OVERRUN),
    .BUSY    (BUSY)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
    STB  = 1'b0;
    SYNC = 1'b0;
    ACK  = 1'b0;
    G_n  = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic sync, input logic ack);
    STB  = 1'b1;
    G_n  = 1'b0;
    DIN  = b;
    SYNC = sync;
    ACK  = ack;
    tick();
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last);
    for (int k = 0; k < 8; k++) send_bit(w[k], 1'b0, ack_last && (k == 7));
  endtask

  task automatic test_reset();
    G_n = 1'b1; SYNC = 1'b0; STB = 1'b0; DIN = 1'b0; ACK = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({S, Q, VALID, OVERRUN, BUSY} !== 14'd0) begin
      failures++;
      $display("FAIL reset_state S=%0d Q=%h V=%b O=%b B=%b required all zero", S, Q, VALID, OVERRUN, BUSY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    SYNC = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) send_bit(bits[k], 1'b0, 1'b0);
    checks++;
    if (S !== 3'd3 || BUSY !== 1'b1 || VALID !== 1'b0) begin
      failures++;
      $display("FAIL frame_mid S=%0d B=%b V=%b required S=3 B=1 V=0", S, BUSY, VALID);
    end
    for (int k = 3; k < 8; k++) send_bit(bits[k], 1'b0, 1'b0);
    checks++;
    if (Q !== 8'h4D || VALID !== 1'b1 || S !== 3'd0 || BUSY !== 1'b0 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL frame_done Q=%h V=%b S=%0d B=%b O=%b required Q=4d V=1 S=0 B=0 O=0",
               Q, VALID, S, BUSY, OVERRUN);
    end
  endtask

  task automatic test_ack();
    ACK = 1'b1;
    tick();
    checks++;
    if (VALID !== 1'b0 || Q !== 8'h4D) begin
      failures++;
      $display("FAIL ack_clear V=%b Q=%h required V=0 Q=4d", VALID, Q);
    end
    ACK = 1'b1;
    tick();
    checks++;
    if (VALID !== 1'b0 || Q !== 8'h4D || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL ack_idle V=%b Q=%h O=%b required V=0 Q=4d O=0", VALID, Q, OVERRUN);
    end
  endtask

  task automatic test_gate();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    for (int k = 0; k < 4; k++) send_bit(bits[k], 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      STB = 1'b1; G_n = 1'b1; DIN = ~bits[4];
      @(posedge clk);
      #1;
      checks++;
      if (S !== 3'd4 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL gate_hold cycle=%0d S=%0d B=%b required S=4 B=1", c, S, BUSY);
      end
    end
    for (int k = 4; k < 8; k++) send_bit(bits[k], 1'b0, 1'b0);
    checks++;
    if (Q !== 8'h4D || VALID !== 1'b1 || S !== 3'd0) begin
      failures++;
      $display("FAIL gate_done Q=%h V=%b S=%0d required Q=4d V=1 S=0", Q, VALID, S);
    end
    ACK = 1'b1;
    tick();
  endtask

  task automatic test_sync();
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    checks++;
    if (S !== 3'd1 || BUSY !== 1'b1 || VALID !== 1'b0 || Q !== 8'h4D) begin
      failures++;
      $display("FAIL sync_realign S=%0d B=%b V=%b Q=%h required S=1 B=1 V=0 Q=4d", S, BUSY, VALID, Q);
    end
    for (int k = 0; k < 7; k++) send_bit(1'b0, 1'b0, 1'b0);
    checks++;
    if (Q !== 8'h01 || VALID !== 1'b1 || S !== 3'd0 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL sync_done Q=%h V=%b S=%0d O=%b required Q=01 V=1 S=0 O=0", Q, VALID, S, OVERRUN);
    end
    ACK = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back_ack();
    send_word(8'hA5, 1'b0);
    checks++;
    if (Q !== 8'hA5 || VALID !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first Q=%h V=%b required Q=a5 V=1", Q, VALID);
    end
    send_word(8'h3C, 1'b1);
    checks++;
    if (Q !== 8'h3C || VALID !== 1'b1 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack Q=%h V=%b O=%b required Q=3c V=1 O=0", Q, VALID, OVERRUN);
    end
    ACK = 1'b1;
    tick();
  endtask

  task automatic test_overrun();
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    checks++;
    if (Q !== 8'h3C || VALID !== 1'b1 || OVERRUN !== 1'b1) begin
      failures++;
      $display("FAIL overrun Q=%h V=%b O=%b required Q=3c V=1 O=1", Q, VALID, OVERRUN);
    end
    ACK = 1'b1;
    tick();
    checks++;
    if (VALID !== 1'b0 || OVERRUN !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky V=%b O=%b required V=0 O=1", VALID, OVERRUN);
    end
  endtask

  task automatic test_midframe_reset();
    send_word(8'h5A, 1'b0);
    for (int k = 0; k < 6; k++) send_bit(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (S !== 3'd0 || Q !== 8'h00 || VALID !== 1'b0 || OVERRUN !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL async_reset S=%0d Q=%h V=%b O=%b B=%b required all zero", S, Q, VALID, OVERRUN, BUSY);
    end
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    send_word(8'hFF, 1'b0);
    checks++;
    if (Q !== 8'hFF || VALID !== 1'b1 || OVERRUN !== 1'b0 || S !== 3'd0) begin
      failures++;
      $display("FAIL after_reset Q=%h V=%b O=%b S=%0d required Q=ff V=1 O=0 S=0", Q, VALID, OVERRUN, S);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ack();
    test_gate();
    test_sync();
    test_back_to_back_ack();
    test_overrun();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_1_to_8_sipo
